riscv_instr_realigner: RTL and testbench
========================================

Name: riscv_instr_realigner

Overview:
- Sits between the prefetch buffer and the compressed decoder in the IF stage.
- Takes a stream of word-aligned 32-bit fetch words and slices it into individual instructions, 16-bit or 32-bit, at halfword granularity.
- Each instruction is presented in bits [31:0] with its PC, ready for the compressed decoder.
- Holds a one-halfword residual register so that 32-bit instructions straddling a word boundary, and branches to halfword-aligned targets, are handled without bubbles beyond those listed below.

Parameters:
- BOOT_ADDR, 32'h0000_0080, PC loaded on reset; bit 0 ignored.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- fetch_valid_i  in  1  fetch word available
- fetch_ready_o  out  1  fetch word consumed this cycle
- fetch_rdata_i  in  32  fetch word; the word address is implied by the internal PC
- instr_valid_o  out  1  instruction valid
- instr_ready_i  in  1  decoder accepts instruction
- instr_rdata_o  out  32  instruction; compressed instructions are zero-extended as {16'h0, hw}
- instr_addr_o  out  32  PC of the instruction
- instr_compressed_o  out  1  1 when instr_rdata_o[1:0] != 2'b11
- branch_i  in  1  redirect/flush request
- branch_addr_i  in  32  target address, halfword aligned

Behaviour:
- Registers: state_q in {ALIGNED, HALF, SKIP}; pc_q[31:0]; resid_q[15:0].
- Reset (rst=1 at a clk edge):
  - state_q=ALIGNED, pc_q={BOOT_ADDR[31:1],1'b0}, resid_q=0.
  - instr_valid_o=0 and fetch_ready_o=0 while rst is high.
- Outputs are combinational from the registers and fetch_rdata_i: 0-cycle latency from fetch word to instruction.
- instr_addr_o=pc_q always.
- Fetch protocol: the fetch side holds fetch_rdata_i stable while fetch_valid_i=1 and fetch_ready_o=0.
- Output protocol: instr_rdata_o is stable while instr_valid_o=1 and instr_ready_i=0.
- A transfer on the output ("accept") is instr_valid_o & instr_ready_i.
- ALIGNED, fetch word w:
  - w[1:0]!=11: instr_rdata_o={16'h0,w[15:0]}, instr_valid_o=fetch_valid_i, fetch_ready_o=accept. On accept: resid_q<=w[31:16], pc_q+=2, next state HALF.
  - w[1:0]==11: instr_rdata_o=w, instr_valid_o=fetch_valid_i, fetch_ready_o=accept. On accept: pc_q+=4, stay ALIGNED.
- HALF (resid_q holds the halfword at pc_q):
  - resid_q[1:0]!=11: instr_rdata_o={16'h0,resid_q}, instr_valid_o=1 regardless of fetch_valid_i, fetch_ready_o=0. On accept: pc_q+=2, next state ALIGNED.
  - resid_q[1:0]==11: instr_rdata_o={w[15:0],resid_q}, instr_valid_o=fetch_valid_i, fetch_ready_o=accept. On accept: resid_q<=w[31:16], pc_q+=4, stay HALF.
- SKIP (entered after a branch to an address with bit 1 set):
  - instr_valid_o=0, fetch_ready_o=fetch_valid_i.
  - On a consumed word: resid_q<=w[31:16], next state HALF.
  - Costs exactly one cycle per skipped word.
- Branch (branch_i=1):
  - Has priority over all other activity: instr_valid_o=0 and fetch_ready_o=1, so any presented word is dropped.
  - At the edge: pc_q<={branch_addr_i[31:1],1'b0}; state_q<=branch_addr_i[1] ? SKIP : ALIGNED; resid_q<=0.
  - A branch in the same cycle as a would-be accept cancels that accept.
- Reset asserted mid-operation overrides branch and any handshake; the residual is discarded.
- pc_q arithmetic is modulo 2^32: 0xFFFF_FFFE+2 wraps to 0.
- No illegal-instruction detection in this block; that is the decoder's job.
- Deliberately no 16'h0 filtering: the all-zero halfword is passed to the decoder as compressed, and the decoder flags it illegal.

Test Plan:
- Reset, fetch 0x00A00093 (addi, 32-bit) at BOOT_ADDR → instr_rdata_o=0x00A00093, addr 0x80, compressed=0; next PC 0x84.
- Fetch 0x45014501 (two c.li), instr_ready_i=1 → two accepts:
  - addr 0x80, then 0x82;
  - both instr_rdata_o=0x00004501;
  - the second is valid with fetch_valid_i=0;
  - exactly one fetch consumed.
- Straddle: words 0x00930001 then 0x000000A0 → c.nop 0x00000001 @0x80, then 0x00A00093 @0x82, state stays HALF with resid_q=0x0000.
- Branch to 0x102, then fetch 0x4505FFFF → first word skipped with no instr_valid; then c.li 0x00004505 @0x102; PC advances to 0x104.
- Backpressure: instr_ready_i=0 for 3 cycles on a straddled instruction → instr_valid_o, instr_rdata_o and instr_addr_o stay constant and fetch_ready_o=0 throughout.
- branch_i and rst together mid-straddle → reset wins: PC=0x80, state ALIGNED, no instruction emitted.

Source files
------------

// File: rtl/riscv_instr_realigner.sv
// -----------------------------------------------------------------------------
// riscv_instr_realigner
//
// Purpose:
//   IF-stage realigner placed between the prefetch buffer and the compressed
//   decoder. Slices a stream of word-aligned 32-bit fetch words into 16-bit and
//   32-bit instructions at halfword granularity. A one-halfword residual
//   register covers 32-bit instructions that straddle a word boundary and
//   branches to halfword-aligned targets.
//
//   Outputs are combinational from the registers and the current fetch word,
//   so there is no latency from fetch word to instruction.
//
// States:
//   ALIGNED | pc_q is word aligned, next instruction starts at fetch word [15:0]
//   HALF    | r_resid holds the halfword at pc_q (lower half of next instr)
//   SKIP    | branched to pc with bit 1 set, drop lower half of next word
//
// Ports:
//   clk                 clock
//   rst                 synchronous active-high reset
//   fetch_valid_i       fetch word available
//   fetch_ready_o       fetch word consumed this cycle
//   fetch_rdata_i[31:0] fetch word at the word address implied by pc
//   instr_valid_o       instruction valid
//   instr_ready_i       decoder accepts instruction
//   instr_rdata_o[31:0] instruction, compressed ones as {16'h0, hw}
//   instr_addr_o[31:0]  PC of the instruction
//   instr_compressed_o  instr_rdata_o[1:0] != 2'b11
//   branch_i            redirect / flush request
//   branch_addr_i[31:0] halfword-aligned redirect target
// -----------------------------------------------------------------------------
module riscv_instr_realigner #(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_valid_i,
  output logic        fetch_ready_o,
  input  logic [31:0] fetch_rdata_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_rdata_o,
  output logic [31:0] instr_addr_o,
  output logic        instr_compressed_o,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i
);

  typedef enum logic [1:0] {
    ALIGNED = 2'd0,
    HALF    = 2'd1,
    SKIP    = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [15:0] r_resid;

  logic        w_word_c;
  logic        w_resid_c;
  logic        w_accept;
  logic        w_unused_baddr0;

  // Bit 0 of the target is meaningless for halfword-aligned code.
  assign w_unused_baddr0 = branch_addr_i[0];

  assign w_word_c  = (fetch_rdata_i[1:0] != 2'b11);
  assign w_resid_c = (r_resid[1:0] != 2'b11);

  always_comb begin
    instr_rdata_o = {16'h0, r_resid};
    instr_valid_o = 1'b0;
    unique case (r_state)
      ALIGNED: begin
        instr_rdata_o = w_word_c ? {16'h0, fetch_rdata_i[15:0]} : fetch_rdata_i;
        instr_valid_o = fetch_valid_i;
      end
      HALF: begin
        if (w_resid_c) begin
          instr_rdata_o = {16'h0, r_resid};
          // The residual alone is a full instruction, no fetch needed.
          instr_valid_o = 1'b1;
        end else begin
          instr_rdata_o = {fetch_rdata_i[15:0], r_resid};
          instr_valid_o = fetch_valid_i;
        end
      end
      default: begin
        instr_rdata_o = {16'h0, r_resid};
        instr_valid_o = 1'b0;
      end
    endcase
    // Reset and branch both suppress any instruction in flight.
    if (rst || branch_i) begin
      instr_valid_o = 1'b0;
    end
  end

  assign w_accept = instr_valid_o & instr_ready_i;

  always_comb begin
    fetch_ready_o = 1'b0;
    if (rst) begin
      fetch_ready_o = 1'b0;
    end else if (branch_i) begin
      // Flush: any presented word belongs to the old path and is dropped.
      fetch_ready_o = 1'b1;
    end else begin
      unique case (r_state)
        ALIGNED: fetch_ready_o = w_accept;
        HALF:    fetch_ready_o = w_resid_c ? 1'b0 : w_accept;
        default: fetch_ready_o = fetch_valid_i;
      endcase
    end
  end

  assign instr_compressed_o = (instr_rdata_o[1:0] != 2'b11);
  assign instr_addr_o       = r_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ALIGNED;
      r_pc    <= {BOOT_ADDR[31:1], 1'b0};
      r_resid <= 16'h0;
    end else if (branch_i) begin
      r_pc    <= {branch_addr_i[31:1], 1'b0};
      r_state <= branch_addr_i[1] ? SKIP : ALIGNED;
      r_resid <= 16'h0;
    end else begin
      unique case (r_state)
        ALIGNED: begin
          if (w_accept) begin
            if (w_word_c) begin
              r_resid <= fetch_rdata_i[31:16];
              r_pc    <= r_pc + 32'd2;
              r_state <= HALF;
            end else begin
              r_pc    <= r_pc + 32'd4;
            end
          end
        end
        HALF: begin
          if (w_accept) begin
            if (w_resid_c) begin
              r_pc    <= r_pc + 32'd2;
              r_state <= ALIGNED;
            end else begin
              // Upper half of this word starts the next instruction.
              r_resid <= fetch_rdata_i[31:16];
              r_pc    <= r_pc + 32'd4;
            end
          end
        end
        default: begin
          if (fetch_valid_i) begin
            r_resid <= fetch_rdata_i[31:16];
            r_state <= HALF;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_instr_realigner.sv
module tb_riscv_instr_realigner;

  logic        clk;
  logic        rst;
  logic        fetch_valid_i;
  logic        fetch_ready_o;
  logic [31:0] fetch_rdata_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_rdata_o;
  logic [31:0] instr_addr_o;
  logic        instr_compressed_o;
  logic        branch_i;
  logic [31:0] branch_addr_i;

  riscv_instr_realigner #(.BOOT_ADDR(32'h0000_0080)) dut (
    .clk                (clk),
    .rst                (rst),
    .fetch_valid_i      (fetch_valid_i),
    .fetch_ready_o      (fetch_ready_o),
    .fetch_rdata_i      (fetch_rdata_i),
    .instr_valid_o      (instr_valid_o),
    .instr_ready_i      (instr_ready_i),
    .instr_rdata_o      (instr_rdata_o),
    .instr_addr_o       (instr_addr_o),
    .instr_compressed_o (instr_compressed_o),
    .branch_i           (branch_i),
    .branch_addr_i      (branch_addr_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        br;
    logic [31:0] baddr;
    logic        fv;
    logic [31:0] fd;
    logic        rdy;
    logic        e_v;
    logic        e_fr;
    logic [31:0] e_d;
    logic [31:0] e_a;
    logic        e_c;
    logic        chk_d;
  } vec_t;

  vec_t vecs[$];
  int   n_tests;
  int   n_fail;

  task automatic add(input logic r, input logic b, input logic [31:0] ba,
                     input logic fv, input logic [31:0] fd, input logic rdy,
                     input logic ev, input logic efr, input logic [31:0] ed,
                     input logic [31:0] ea, input logic ec, input logic cd);
    vec_t v;
    v.rst = r; v.br = b; v.baddr = ba; v.fv = fv; v.fd = fd; v.rdy = rdy;
    v.e_v = ev; v.e_fr = efr; v.e_d = ed; v.e_a = ea; v.e_c = ec; v.chk_d = cd;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got 0x%08h expected 0x%08h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic b, input logic [31:0] ba,
                       input logic fv, input logic [31:0] fd, input logic rdy);
    @(negedge clk);
    rst = r; branch_i = b; branch_addr_i = ba;
    fetch_valid_i = fv; fetch_rdata_i = fd; instr_ready_i = rdy;
    #2;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1; branch_i = 1'b0; branch_addr_i = 32'h0;
    fetch_valid_i = 1'b0; fetch_rdata_i = 32'h0; instr_ready_i = 1'b0;

    //  rst br baddr         fv fd            rdy  v  fr  data          addr          c  chk
    add(1, 0, 32'h0,         0, 32'h0,         0,  0, 0, 32'h0,         32'h0,        0, 0);
    add(1, 0, 32'h0,         0, 32'h0,         0,  0, 0, 32'h0,         32'h80,       1, 1);
    // 32-bit addi at boot address
    add(0, 0, 32'h0,         1, 32'h00A00093,  1,  1, 1, 32'h00A00093,  32'h80,       0, 1);
    add(0, 0, 32'h0,         0, 32'h0,         1,  0, 0, 32'h0,         32'h84,       1, 1);
    // two c.li from one word
    add(1, 0, 32'h0,         0, 32'h0,         1,  0, 0, 32'h0,         32'h84,       1, 1);
    add(0, 0, 32'h0,         1, 32'h45014501,  1,  1, 1, 32'h00004501,  32'h80,       1, 1);
    add(0, 0, 32'h0,         0, 32'hDEADBEEF,  1,  1, 0, 32'h00004501,  32'h82,       1, 1);
    add(0, 0, 32'h0,         0, 32'h0,         1,  0, 0, 32'h0,         32'h84,       1, 1);
    // straddle: c.nop then addi across word boundary
    add(1, 0, 32'h0,         0, 32'h0,         1,  0, 0, 32'h0,         32'h84,       1, 1);
    add(0, 0, 32'h0,         1, 32'h00930001,  1,  1, 1, 32'h00000001,  32'h80,       1, 1);
    add(0, 0, 32'h0,         1, 32'h000000A0,  1,  1, 1, 32'h00A00093,  32'h82,       0, 1);
    add(0, 0, 32'h0,         0, 32'hFFFFFFFF,  0,  1, 0, 32'h0,         32'h86,       1, 1);
    add(0, 0, 32'h0,         0, 32'hFFFFFFFF,  1,  1, 0, 32'h0,         32'h86,       1, 1);
    // branch to 0x102, skipped lower half
    add(0, 1, 32'h102,       1, 32'h12345678,  1,  0, 1, 32'h00005678,  32'h88,       1, 1);
    add(0, 0, 32'h0,         1, 32'h4505FFFF,  1,  0, 1, 32'h0,         32'h102,      1, 1);
    add(0, 0, 32'h0,         0, 32'h0,         1,  1, 0, 32'h00004505,  32'h102,      1, 1);
    add(0, 0, 32'h0,         0, 32'h0,         0,  0, 0, 32'h0,         32'h104,      1, 1);
    // backpressure on a straddled instruction
    add(1, 0, 32'h0,         0, 32'h0,         1,  0, 0, 32'h0,         32'h104,      1, 1);
    add(0, 0, 32'h0,         1, 32'h00930001,  1,  1, 1, 32'h00000001,  32'h80,       1, 1);
    add(0, 0, 32'h0,         1, 32'h000000A0,  0,  1, 0, 32'h00A00093,  32'h82,       0, 1);
    add(0, 0, 32'h0,         1, 32'h000000A0,  0,  1, 0, 32'h00A00093,  32'h82,       0, 1);
    add(0, 0, 32'h0,         1, 32'h000000A0,  0,  1, 0, 32'h00A00093,  32'h82,       0, 1);
    add(0, 0, 32'h0,         1, 32'h000000A0,  1,  1, 1, 32'h00A00093,  32'h82,       0, 1);
    // reset and branch together mid-straddle: reset wins
    add(1, 0, 32'h0,         0, 32'h0,         1,  0, 0, 32'h0,         32'h86,       1, 1);
    add(0, 0, 32'h0,         1, 32'h00930001,  1,  1, 1, 32'h00000001,  32'h80,       1, 1);
    add(1, 1, 32'h202,       1, 32'h000000A0,  1,  0, 0, 32'h00A00093,  32'h82,       0, 1);
    add(0, 0, 32'h0,         0, 32'h00000013,  1,  0, 0, 32'h00000013,  32'h80,       0, 1);
    add(0, 0, 32'h0,         1, 32'h00000013,  1,  1, 1, 32'h00000013,  32'h80,       0, 1);
    // PC wrap at the top of the address space
    add(0, 1, 32'hFFFFFFFE,  0, 32'h0,         1,  0, 1, 32'h0,         32'h84,       1, 1);
    add(0, 0, 32'h0,         1, 32'h00014501,  1,  0, 1, 32'h0,         32'hFFFFFFFE, 1, 1);
    add(0, 0, 32'h0,         0, 32'h0,         1,  1, 0, 32'h00000001,  32'hFFFFFFFE, 1, 1);
    add(0, 0, 32'h0,         0, 32'h0,         1,  0, 0, 32'h0,         32'h0,        1, 1);
    // branch to word-aligned target goes straight to ALIGNED
    add(0, 1, 32'h200,       1, 32'h00A00093,  1,  0, 1, 32'h00A00093,  32'h0,        0, 1);
    add(0, 0, 32'h0,         1, 32'h00A00093,  1,  1, 1, 32'h00A00093,  32'h200,      0, 1);
    add(0, 0, 32'h0,         0, 32'h0,         1,  0, 0, 32'h0,         32'h204,      1, 1);
    // SKIP waits for a fetch word
    add(0, 1, 32'h302,       0, 32'h0,         1,  0, 1, 32'h0,         32'h204,      1, 1);
    add(0, 0, 32'h0,         0, 32'h4505FFFF,  1,  0, 0, 32'h0,         32'h302,      1, 1);
    add(0, 0, 32'h0,         1, 32'h4505FFFF,  1,  0, 1, 32'h0,         32'h302,      1, 1);
    add(0, 0, 32'h0,         0, 32'h0,         1,  1, 0, 32'h00004505,  32'h302,      1, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].br, vecs[i].baddr, vecs[i].fv, vecs[i].fd, vecs[i].rdy);
      chk("instr_valid", i, {31'h0, instr_valid_o}, {31'h0, vecs[i].e_v});
      chk("fetch_ready", i, {31'h0, fetch_ready_o}, {31'h0, vecs[i].e_fr});
      if (vecs[i].chk_d) begin
        chk("instr_rdata", i, instr_rdata_o, vecs[i].e_d);
        chk("instr_addr", i, instr_addr_o, vecs[i].e_a);
        chk("instr_compressed", i, {31'h0, instr_compressed_o}, {31'h0, vecs[i].e_c});
      end
    end

    // Hand sequence: branch cancels an accept of a residual-only instruction.
    drive(1, 0, 32'h0, 0, 32'h0, 1);
    drive(0, 0, 32'h0, 1, 32'h45014501, 1);
    chk("seq_first_c", 100, instr_rdata_o, 32'h00004501);
    drive(0, 1, 32'h400, 0, 32'h0, 1);
    chk("seq_branch_valid", 101, {31'h0, instr_valid_o}, 32'h0);
    chk("seq_branch_ready", 102, {31'h0, fetch_ready_o}, 32'h1);
    drive(0, 0, 32'h0, 1, 32'h00A00093, 0);
    chk("seq_target_addr", 103, instr_addr_o, 32'h400);
    chk("seq_target_valid", 104, {31'h0, instr_valid_o}, 32'h1);
    chk("seq_target_data", 105, instr_rdata_o, 32'h00A00093);
    chk("seq_stall_ready", 106, {31'h0, fetch_ready_o}, 32'h0);
    drive(0, 0, 32'h0, 1, 32'h00A00093, 1);
    chk("seq_accept_ready", 107, {31'h0, fetch_ready_o}, 32'h1);
    drive(0, 0, 32'h0, 0, 32'h0, 1);
    chk("seq_next_addr", 108, instr_addr_o, 32'h404);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
